// File: rtl/halfband_coeff_ctrl_pkg.sv
// Shared constants, FSM encoding and default coefficient set (Fp=0.21875) for the halfband
// filter and its run-time coefficient controller.
package halfband_coeff_ctrl_pkg;

    localparam int unsigned WIDTH       = 18;
    localparam int unsigned NCOEF       = 8;
    localparam int unsigned COEF_ADDR_W = 3;
    localparam int unsigned IDX_W       = $clog2(NCOEF);
    localparam int unsigned FLUSH_CYC   = 19;
    localparam int unsigned CNT_W       = $clog2(FLUSH_CYC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_SAM,
        ST_FLUSH
    } state_t;

    typedef logic [NCOEF-1:0][WIDTH-1:0] bank_t;

    // Element 0 is the outermost tap, element NCOEF-1 the centre tap.
    localparam bank_t DEFAULT_BANK = {
        WIDTH'(65536), WIDTH'(39204), WIDTH'(0), WIDTH'(-7848),
        WIDTH'(0),     WIDTH'(1572),  WIDTH'(0), WIDTH'(-161)
    };

endpackage

// File: rtl/halfband_coeff_bank.sv
// Shadow and active coefficient banks with the written-index mask; active bank updates only
// on the swap strobe.
module halfband_coeff_bank
    import halfband_coeff_ctrl_pkg::*;
(
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   swap,
    output logic                   full_c,
    output logic [NCOEF*WIDTH-1:0] active_flat
);

    bank_t            shadow;
    bank_t            active;
    logic [NCOEF-1:0] mask;
    logic [NCOEF-1:0] wr_onehot_c;

    // Completeness includes a write landing this cycle so it can coincide with the commit.
    always_comb begin
        wr_onehot_c = '0;
        if (wr_en) begin
            wr_onehot_c[wr_idx] = 1'b1;
        end
    end

    assign full_c      = &(mask | wr_onehot_c);
    assign active_flat = active;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            shadow <= DEFAULT_BANK;
            active <= DEFAULT_BANK;
            mask   <= '0;
        end else begin
            if (wr_en) begin
                shadow[wr_idx] <= wr_data;
            end
            if (swap) begin
                active <= shadow;
                mask   <= '0;
            end else begin
                mask <= mask | wr_onehot_c;
            end
        end
    end

endmodule

// File: rtl/halfband_coeff_ctrl.sv
// Coefficient controller: collects shadow writes, commits them on a sample boundary and
// mutes the halfband output while its tap line and pipeline refill.
module halfband_coeff_ctrl
    import halfband_coeff_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = COEF_ADDR_W
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   sam_clk_en,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   commit_req,
    output logic                   commit_ack,
    output logic                   commit_err,
    output logic                   busy,
    output logic                   mute,
    output logic [NCOEF*WIDTH-1:0] hsys_flat
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wr_fire_c;
    logic             wr_en_c;
    logic             full_c;
    logic             swap_c;
    logic             ack_nxt;
    logic             err_nxt;

    // Out-of-range addresses still complete the handshake but never reach the bank.
    assign wr_fire_c = wr_valid & wr_ready;
    assign wr_en_c   = wr_fire_c && (32'(wr_addr) < NCOEF);

    halfband_coeff_bank u_bank (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .wr_en       (wr_en_c),
        .wr_idx      (IDX_W'(wr_addr)),
        .wr_data     (wr_data),
        .swap        (swap_c),
        .full_c      (full_c),
        .active_flat (hsys_flat)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        swap_c    = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE, ST_LOAD: begin
                if (wr_fire_c) begin
                    state_nxt = ST_LOAD;
                end
                if (commit_req) begin
                    if (full_c) begin
                        state_nxt = ST_WAIT_SAM;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_WAIT_SAM: begin
                if (sam_clk_en) begin
                    swap_c    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (cnt == CNT_W'(FLUSH_CYC - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Ack marks the last flush cycle, so it rides alongside the final mute cycle.
        ack_nxt = (state_nxt == ST_FLUSH) && (cnt_nxt == CNT_W'(FLUSH_CYC - 1));
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            wr_ready   <= 1'b1;
            commit_ack <= 1'b0;
            commit_err <= 1'b0;
            busy       <= 1'b0;
            mute       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wr_ready   <= (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD);
            commit_ack <= ack_nxt;
            commit_err <= err_nxt;
            busy       <= (state_nxt == ST_WAIT_SAM) || (state_nxt == ST_FLUSH);
            mute       <= (state_nxt == ST_FLUSH);
        end
    end

endmodule

// File: tb/tb_halfband_coeff_ctrl.sv
// Randomized scenario bench for halfband_coeff_ctrl against a coefficient-bank reference model.
module tb_halfband_coeff_ctrl;

    logic         sys_clk = 1'b0;
    logic         reset;
    logic         sam_clk_en;
    logic         wr_valid;
    logic         wr_ready;
    logic [3:0]   wr_addr;
    logic [17:0]  wr_data;
    logic         commit_req;
    logic         commit_ack;
    logic         commit_err;
    logic         busy;
    logic         mute;
    logic [143:0] hsys_flat;

    int n_checks = 0;
    int n_pass   = 0;

    logic [17:0] shadow_m [8];
    logic [17:0] active_m [8];
    bit          written_m[8];
    int          defaults [8] = '{-161, 0, 1572, 0, -7848, 0, 39204, 65536};

    halfband_coeff_ctrl #(.ADDR_W(4)) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit_req (commit_req),
        .commit_ack (commit_ack),
        .commit_err (commit_err),
        .busy       (busy),
        .mute       (mute),
        .hsys_flat  (hsys_flat)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            shadow_m[i]  = 18'(defaults[i]);
            active_m[i]  = 18'(defaults[i]);
            written_m[i] = 1'b0;
        end
    endfunction

    function automatic bit model_full();
        bit f = 1'b1;
        for (int i = 0; i < 8; i++) f &= written_m[i];
        return f;
    endfunction

    function automatic logic [143:0] exp_flat();
        logic [143:0] v;
        for (int i = 0; i < 8; i++) v[i*18 +: 18] = active_m[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_write(input int addr, input logic [17:0] data);
        n_checks++;
        if (wr_ready !== 1'b1) $display("FAIL write_ready addr=%0d: got %b want 1", addr, wr_ready);
        else n_pass++;
        wr_valid = 1'b1; wr_addr = 4'(addr); wr_data = data;
        tick();
        wr_valid = 1'b0;
        if (addr < 8) begin
            shadow_m[addr]  = data;
            written_m[addr] = 1'b1;
        end
    endtask

    // Commit request, optionally with a write in the same cycle; refused unless every index written.
    task automatic do_commit(input bit with_write, input int addr, input logic [17:0] data);
        bit exp_ok;
        commit_req = 1'b1;
        if (with_write) begin
            wr_valid = 1'b1; wr_addr = 4'(addr); wr_data = data;
        end
        tick();
        commit_req = 1'b0; wr_valid = 1'b0;
        if (with_write && addr < 8) begin
            shadow_m[addr]  = data;
            written_m[addr] = 1'b1;
        end
        exp_ok = model_full();
        n_checks++;
        if (commit_err !== !exp_ok) $display("FAIL commit_err: got %b want %b", commit_err, !exp_ok);
        else n_pass++;
        n_checks++;
        if (busy !== exp_ok) $display("FAIL commit_busy: got %b want %b", busy, exp_ok);
        else n_pass++;
        n_checks++;
        if (hsys_flat !== exp_flat()) $display("FAIL commit_active_held: got %h want %h", hsys_flat, exp_flat());
        else n_pass++;
        if (!exp_ok) begin
            tick();
            n_checks++;
            if (commit_err !== 1'b0 || wr_ready !== 1'b1)
                $display("FAIL err_pulse: err=%b ready=%b want 0/1", commit_err, wr_ready);
            else n_pass++;
        end
    endtask

    // Wait `delay` cycles in WAIT_SAM, strobe sam_clk_en, then measure the flush window.
    task automatic swap_and_flush(input int delay, input bit hold_req);
        int mute_cnt = 0, acks = 0, ack_pos = -1, errs = 0;
        if (hold_req) commit_req = 1'b1;
        for (int d = 0; d < delay; d++) begin
            sam_clk_en = 1'b0;
            tick();
            n_checks++;
            if (busy !== 1'b1 || mute !== 1'b0 || wr_ready !== 1'b0 || hsys_flat !== exp_flat())
                $display("FAIL wait_sam d=%0d: busy=%b mute=%b ready=%b flat=%h want 1/0/0 %h",
                         d, busy, mute, wr_ready, hsys_flat, exp_flat());
            else n_pass++;
        end
        sam_clk_en = 1'b1;
        tick();
        sam_clk_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            active_m[i]  = shadow_m[i];
            written_m[i] = 1'b0;
        end
        n_checks++;
        if (hsys_flat !== exp_flat()) $display("FAIL swap_value: got %h want %h", hsys_flat, exp_flat());
        else n_pass++;
        for (int k = 0; k < 40; k++) begin
            if (!mute) break;
            mute_cnt++;
            if (commit_err) errs++;
            if (commit_ack) begin
                acks++;
                ack_pos = mute_cnt;
                commit_req = 1'b0;
            end
            tick();
        end
        commit_req = 1'b0;
        n_checks++;
        if (mute_cnt !== 19) $display("FAIL mute_len: got %0d want 19", mute_cnt);
        else n_pass++;
        n_checks++;
        if (acks !== 1 || ack_pos !== 19) $display("FAIL ack_pulse: count=%0d pos=%0d want 1 at 19", acks, ack_pos);
        else n_pass++;
        n_checks++;
        if (errs !== 0) $display("FAIL flush_err: got %0d err pulses want 0", errs);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b1 || commit_ack !== 1'b0 || hsys_flat !== exp_flat())
            $display("FAIL post_flush: busy=%b ready=%b ack=%b flat=%h want 0/1/0 %h",
                     busy, wr_ready, commit_ack, hsys_flat, exp_flat());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        model_reset();
        n_checks++;
        if (hsys_flat[6*18 +: 18] !== 18'(39204)) $display("FAIL reset_idx6: got %0d want 39204", hsys_flat[6*18 +: 18]);
        else n_pass++;
        n_checks++;
        if (hsys_flat[7*18 +: 18] !== 18'(65536)) $display("FAIL reset_idx7: got %0d want 65536", hsys_flat[7*18 +: 18]);
        else n_pass++;
        n_checks++;
        if ($signed(hsys_flat[0 +: 18]) !== -18'sd161) $display("FAIL reset_idx0: got %0d want -161", $signed(hsys_flat[0 +: 18]));
        else n_pass++;
        n_checks++;
        if (hsys_flat !== exp_flat()) $display("FAIL reset_bank: got %h want %h", hsys_flat, exp_flat());
        else n_pass++;
        n_checks++;
        if (mute !== 1'b0 || wr_ready !== 1'b1 || busy !== 1'b0 || commit_ack !== 1'b0 || commit_err !== 1'b0)
            $display("FAIL reset_flags: mute=%b ready=%b busy=%b ack=%b err=%b want 0/1/0/0/0",
                     mute, wr_ready, busy, commit_ack, commit_err);
        else n_pass++;
    endtask

    task automatic test_full_commit();
        for (int i = 0; i < 8; i++) do_write(i, 18'(1000 * i));
        do_commit(1'b0, 0, '0);
        swap_and_flush(4, 1'b0);
    endtask

    task automatic test_commit_idle();
        do_commit(1'b0, 0, '0);
    endtask

    task automatic test_incomplete_then_coincide();
        for (int i = 0; i < 7; i++) do_write(i, 18'($urandom));
        do_commit(1'b0, 0, '0);
        do_commit(1'b1, 7, 18'($urandom));
        swap_and_flush(int'($urandom_range(0, 6)), 1'b1);
    endtask

    task automatic test_overwrite_and_bad_addr();
        for (int i = 0; i < 7; i++) do_write(i, 18'($urandom));
        do_write(9, 18'($urandom));
        do_commit(1'b0, 0, '0);
        do_write(7, 18'(100));
        do_write(7, 18'(-200));
        do_write(9, 18'($urandom));
        do_commit(1'b0, 0, '0);
        swap_and_flush(2, 1'b0);
        n_checks++;
        if ($signed(hsys_flat[7*18 +: 18]) !== -18'sd200) $display("FAIL overwrite_idx7: got %0d want -200", $signed(hsys_flat[7*18 +: 18]));
        else n_pass++;
    endtask

    task automatic test_sam_on_entry();
        for (int i = 7; i >= 0; i--) do_write(i, 18'($urandom));
        sam_clk_en = 1'b1;
        do_commit(1'b0, 0, '0);
        n_checks++;
        if (mute !== 1'b0) $display("FAIL sam_entry_mute: got %b want 0", mute);
        else n_pass++;
        swap_and_flush(0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 12; n++) do_write(int'($urandom_range(0, 9)), 18'($urandom));
            for (int i = 0; i < 8; i++) if (!written_m[i]) do_write(i, 18'($urandom));
            do_commit(1'b0, 0, '0);
            swap_and_flush(int'($urandom_range(0, 8)), r[0]);
        end
    endtask

    task automatic test_reset_in_flush();
        for (int i = 0; i < 8; i++) do_write(i, 18'($urandom));
        do_commit(1'b0, 0, '0);
        sam_clk_en = 1'b1;
        tick();
        sam_clk_en = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        n_checks++;
        if (mute !== 1'b1) $display("FAIL mid_flush_mute: got %b want 1", mute);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        n_checks++;
        if (mute !== 1'b0 || wr_ready !== 1'b1 || busy !== 1'b0 || hsys_flat !== exp_flat())
            $display("FAIL reset_in_flush: mute=%b ready=%b busy=%b flat=%h want 0/1/0 %h",
                     mute, wr_ready, busy, hsys_flat, exp_flat());
        else n_pass++;
        tick();
        n_checks++;
        if (mute !== 1'b0 || commit_ack !== 1'b0 || hsys_flat !== exp_flat())
            $display("FAIL after_reset_flush: mute=%b ack=%b want 0/0", mute, commit_ack);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1; sam_clk_en = 1'b0; wr_valid = 1'b0; wr_addr = '0;
        wr_data = '0; commit_req = 1'b0;
        model_reset();
        test_reset();
        test_full_commit();
        test_commit_idle();
        test_incomplete_then_coincide();
        test_overwrite_and_bad_addr();
        test_sam_on_entry();
        test_back_to_back();
        test_reset_in_flush();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
